_gate_bist: RTL and testbench
=============================

# _gate_bist

Built-in self-test sequencer for the combinational gate library. It drives every input combination of an N_IN-input gate under test (e.g. `_and`, `_nand`) and holds each vector for a programmable settle time. It samples the gate output, compares it against a parameterised truth table, and reports pass/fail per vector. It sits on the board between the push-button/LED glue and any gate instance, replacing hand-written simulation checks with an on-hardware sweep.

## Interface
Parameters:
- N_IN, 2, number of gate-under-test inputs (1..4); sweep length is 2^N_IN vectors
- EXP, 4'b1000, expected truth table, 2^N_IN bits; bit i = expected output for input vector i (default = AND)
- SETTLE, 1, extra cycles each vector is held before sampling (0..15)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a sweep; accepted only in IDLE
- abort  in  1  stop a running sweep, return to IDLE without done
- dut_in  out  N_IN  input vector driven to the gate under test
- dut_out  in  1  gate-under-test output
- busy  out  1  high while a sweep is running
- done  out  1  one-cycle pulse when a sweep completes
- pass  out  1  1 = last completed sweep had zero mismatches; held until next start
- fail_vec  out  2^N_IN  bit i set if vector i mismatched in last sweep
- err_count  out  N_IN+1  number of mismatches in last sweep

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst_n=0 at an edge) in any state, including mid-sweep: state=IDLE, dut_in=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0, idx=0, cnt=0.
- IDLE: dut_in=0. On start=1 at an edge: RUN, idx=0, cnt=0, fail_vec=0, err_count=0, pass=0, busy=1.
- RUN: dut_in=idx. At each edge:
  - abort=1 takes priority: IDLE, busy=0, dut_in=0, done not pulsed, pass=0, fail_vec/err_count keep partial values.
  - else if cnt<SETTLE: cnt++.
  - else (cnt==SETTLE): compare dut_out with EXP[idx]; on mismatch set fail_vec[idx], err_count++. If idx==2^N_IN-1: DONE, busy=0, done=1, pass=(final err_count==0), counting this vector's result. Otherwise idx++, cnt=0.
- DONE: lasts exactly one cycle; next edge returns to IDLE with done=0. start in DONE is ignored.
- start while busy is ignored; abort in IDLE/DONE has no effect.
- err_count cannot overflow: its maximum is 2^N_IN, which fits in N_IN+1 bits.

## Timing
- Edge E0 accepts start; vector 0 appears on dut_in in the cycle after E0.
- Each vector is held SETTLE+1 cycles and sampled at its last edge.
- Last sample edge = E0 + 2^N_IN*(SETTLE+1). At that edge done rises and busy falls. done is high for one cycle.
- Defaults (N_IN=2, SETTLE=1): done high in the cycle after E0+8.
- A new start is accepted at the earliest in IDLE, one cycle after done.
- All outputs are registered; dut_out is sampled combinationally at the compare edge, with no input synchroniser.

## Test plan
- Correct AND, defaults: start pulse → dut_in steps 0,0,1,1,2,2,3,3 → done at E0+8, pass=1, fail_vec=0000, err_count=0.
- Stuck-at-0 output, EXP=1000: → pass=0, fail_vec=1000, err_count=1.
- NAND wired with EXP=1000: → fail_vec=1111, err_count=4, pass=0.
- start re-pulsed at E0+3 and during DONE: no restart; done at E0+8 only. abort at E0+4: IDLE next cycle, dut_in=0, no done, busy=0.
- rst_n=0 at E0+5: all outputs 0 next cycle. A following start runs a full clean sweep.
- SETTLE=0, N_IN=1, EXP=2'b01 (inverter): dut_in 0,1 → done at E0+2, pass=1.

Source files
------------

// File: rtl/_gate_bist.sv
// Exhaustive-sweep self-test sequencer for an N_IN-input combinational gate.
// Holds each input vector SETTLE+1 cycles, compares against EXP, reports per-vector result.
module _gate_bist #(
    parameter int unsigned          N_IN   = 2,
    parameter logic [2**N_IN-1:0]   EXP    = 4'b1000,
    parameter int unsigned          SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   fail_vec,
    output logic [N_IN:0]        err_count
);

    localparam int unsigned NV = 2 ** N_IN;
    localparam int unsigned EW = N_IN + 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);
    localparam logic [N_IN-1:0] LAST     = N_IN'(NV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic            mismatch;

    // Gate output is compared directly at the sample edge, no synchroniser.
    always_comb begin
        mismatch = (dut_out != EXP[idx]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        idx       <= '0;
                        cnt       <= '0;
                        dut_in    <= '0;
                        fail_vec  <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Partial results stay visible; no done pulse.
                        state  <= IDLE;
                        busy   <= 1'b0;
                        dut_in <= '0;
                        pass   <= 1'b0;
                        idx    <= '0;
                        cnt    <= '0;
                    end else if (cnt != SETTLE_C) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        if (mismatch) begin
                            fail_vec[idx] <= 1'b1;
                            err_count     <= err_count + EW'(1);
                        end
                        if (idx == LAST) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= (err_count == '0) && !mismatch;
                            dut_in <= '0;
                            idx    <= '0;
                            cnt    <= '0;
                        end else begin
                            idx    <= idx + N_IN'(1);
                            dut_in <= idx + N_IN'(1);
                            cnt    <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb__gate_bist.sv
// Randomized bench for _gate_bist: two configurations, emulated gate via a truth table,
// expected timing/results computed from sweep arithmetic.
module tb__gate_bist;

    localparam logic [3:0] EXP_A    = 4'b1000;
    localparam int         SETTLE_A = 1;
    localparam int         NV_A     = 4;
    localparam int         LAST_A   = NV_A * (SETTLE_A + 1);

    localparam logic [1:0] EXP_B    = 2'b01;
    localparam int         LAST_B   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, abort_a, start_b, abort_b;
    logic [1:0] dut_in_a;
    logic       dut_out_a, busy_a, done_a, pass_a;
    logic [3:0] fail_vec_a;
    logic [2:0] err_count_a;
    logic [0:0] dut_in_b;
    logic       dut_out_b, busy_b, done_b, pass_b;
    logic [1:0] fail_vec_b;
    logic [1:0] err_count_b;
    logic [3:0] tt_a;
    logic [1:0] tt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Emulated gates under test: arbitrary truth tables.
    assign dut_out_a = tt_a[dut_in_a];
    assign dut_out_b = tt_b[dut_in_b];

    _gate_bist #(.N_IN(2), .EXP(EXP_A), .SETTLE(SETTLE_A)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail_vec(fail_vec_a), .err_count(err_count_a)
    );

    _gate_bist #(.N_IN(1), .EXP(EXP_B), .SETTLE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail_vec(fail_vec_b), .err_count(err_count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_a(input string tag, input logic b, input logic d, input logic [1:0] vin,
                           input logic p, input logic [3:0] fv, input logic [2:0] ec);
        check({tag, ".busy"},      32'(busy_a),      32'(b));
        check({tag, ".done"},      32'(done_a),      32'(d));
        check({tag, ".dut_in"},    32'(dut_in_a),    32'(vin));
        check({tag, ".pass"},      32'(pass_a),      32'(p));
        check({tag, ".fail_vec"},  32'(fail_vec_a),  32'(fv));
        check({tag, ".err_count"}, 32'(err_count_a), 32'(ec));
    endtask

    // One sweep of instance A; abort_at / rst_at are edge offsets from E0 (0 = none).
    task automatic run_a(input logic [3:0] tt, input int abort_at, input int rst_at, input bit repulse);
        logic [3:0] bad, part;
        int         stop_t, m;
        bad  = tt ^ EXP_A;
        tt_a = tt;
        stop_t = LAST_A + 2;
        if (abort_at > 0) stop_t = abort_at + 2;
        if (rst_at > 0)   stop_t = rst_at + 2;
        start_a = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t <= stop_t; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            start_a = 1'b0;
            abort_a = 1'b0;
            rst_n   = 1'b1;
            if (rst_at > 0 && t >= rst_at) begin
                check_a("rst", 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 3'd0);
            end else if (abort_at > 0 && t >= abort_at) begin
                m    = (abort_at - 1) / (SETTLE_A + 1);
                part = bad & 4'((1 << m) - 1);
                check_a("abort", 1'b0, 1'b0, 2'd0, 1'b0, part, 3'($countones(part)));
            end else if (t < LAST_A) begin
                check({"run.busy"},   32'(busy_a),   32'd1);
                check({"run.done"},   32'(done_a),   32'd0);
                check({"run.dut_in"}, 32'(dut_in_a), 32'(t / (SETTLE_A + 1)));
            end else begin
                check_a(t == LAST_A ? "end" : "post", 1'b0, t == LAST_A, 2'd0,
                        bad == 4'd0, bad, 3'($countones(bad)));
            end
            if (t + 1 == abort_at) abort_a = 1'b1;
            if (t + 1 == rst_at)   rst_n   = 1'b0;
            if (repulse && (t + 1 == 3 || t + 1 == LAST_A + 1)) start_a = 1'b1;
        end
        start_a = 1'b0;
        abort_a = 1'b0;
        rst_n   = 1'b1;
        // Abort while idle has no effect.
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        check("idle_abort.busy", 32'(busy_a), 32'd0);
        check("idle_abort.done", 32'(done_a), 32'd0);
    endtask

    // One sweep of instance B (inverter table, no settle).
    task automatic run_b(input logic [1:0] tt);
        logic [1:0] bad;
        bad  = tt ^ EXP_B;
        tt_b = tt;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int t = 0; t <= LAST_B + 1; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            if (t < LAST_B) begin
                check("b.busy",   32'(busy_b),   32'd1);
                check("b.dut_in", 32'(dut_in_b), 32'(t));
                check("b.done",   32'(done_b),   32'd0);
            end else begin
                check("b.done",      32'(done_b),      32'(t == LAST_B));
                check("b.busy",      32'(busy_b),      32'd0);
                check("b.pass",      32'(pass_b),      32'(bad == 2'd0));
                check("b.fail_vec",  32'(fail_vec_b),  32'(bad));
                check("b.err_count", 32'(err_count_b), 32'($countones(bad)));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        tt_a = 4'b1000; tt_b = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        check_a("reset", 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 3'd0);
        check("reset.b_busy", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_a(4'b1000, 0, 0, 1'b0);              // correct AND
        run_a(4'b0000, 0, 0, 1'b0);              // stuck-at-0
        run_a(4'b0111, 0, 0, 1'b0);              // NAND against AND table
        run_a(4'b1000, 0, 0, 1'b1);              // restart pulses ignored
        run_a(4'b0110, 4, 0, 1'b0);              // abort at E0+4
        run_a(4'b0110, 0, 5, 1'b0);              // reset at E0+5
        run_a(4'b1000, 0, 0, 1'b0);              // clean sweep after reset
        for (int i = 0; i < 24; i++) begin
            int mode;
            mode = $urandom_range(0, 3);
            run_a(4'($urandom), mode == 1 ? $urandom_range(1, LAST_A) : 0,
                  mode == 2 ? $urandom_range(1, LAST_A) : 0, mode == 3);
        end

        run_b(2'b01);
        run_b(2'b10);
        for (int i = 0; i < 4; i++) run_b(2'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
